// File: rtl/pc_branch_unit.sv
// Program counter and branch resolution stage: latches ALU flags, resolves branches,
// selects the next PC and handles a single-level overflow trap with EPC save/restore.
module pc_branch_unit #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [15:0] TRAP_VECTOR = 16'h0004
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] ALU_Result,
  input  logic [15:0] ALU_Out,
  input  logic [11:0] Jump_Target,
  input  logic        EQ,
  input  logic        GR,
  input  logic        LT,
  input  logic        Zero,
  input  logic        Ovfl,
  input  logic        Flag_Write,
  input  logic        PC_Write,
  input  logic        PC_Write_Cond,
  input  logic [2:0]  Branch_Cond,
  input  logic [1:0]  PC_Src,
  input  logic        Ovfl_Trap_En,
  input  logic        Trap_Return,
  output logic [15:0] PC,
  output logic [15:0] EPC,
  output logic [4:0]  Flags,
  output logic        Branch_Taken,
  output logic        Trap,
  output logic        In_Trap
);

  typedef enum logic {IDLE = 1'b0, IN_TRAP = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] epc_q, epc_d;
  logic [4:0]  flags_q, flags_d;
  logic        trap_q, trap_d;
  logic        cond;
  logic [15:0] src_pc;

  // Flags layout: {Ovfl, Zero, LT, GR, EQ}
  always_comb begin
    cond = 1'b0;
    case (Branch_Cond)
      3'b000: cond = flags_q[0];
      3'b001: cond = ~flags_q[0];
      3'b010: cond = flags_q[2];
      3'b011: cond = ~flags_q[2];
      3'b100: cond = flags_q[1];
      3'b101: cond = ~flags_q[1];
      3'b110: cond = flags_q[3];
      default: cond = 1'b1;
    endcase
  end

  assign Branch_Taken = PC_Write_Cond & cond;

  always_comb begin
    src_pc = ALU_Result;
    case (PC_Src)
      2'b00: src_pc = ALU_Result;
      2'b01: src_pc = ALU_Out;
      2'b10: src_pc = {pc_q[15:13], Jump_Target, 1'b0};
      default: src_pc = epc_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    trap_d  = 1'b0;
    flags_d = Flag_Write ? {Ovfl, Zero, LT, GR, EQ} : flags_q;
    case (state_q)
      IDLE: begin
        if (Flag_Write && Ovfl && Ovfl_Trap_En) begin
          epc_d   = pc_q;
          pc_d    = TRAP_VECTOR;
          trap_d  = 1'b1;
          state_d = IN_TRAP;
        end else if (PC_Write || Branch_Taken) begin
          pc_d = src_pc;
        end
      end
      IN_TRAP: begin
        // Return wins over PC writes; overflow is masked while trapped.
        if (Trap_Return) begin
          pc_d    = epc_q;
          state_d = IDLE;
        end else if (PC_Write || Branch_Taken) begin
          pc_d = src_pc;
        end
      end
      default: state_d = IDLE;
    endcase
    pc_d[0] = 1'b0;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      epc_q   <= 16'h0000;
      flags_q <= 5'b00000;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      flags_q <= flags_d;
      trap_q  <= trap_d;
    end
  end

  assign PC      = pc_q;
  assign EPC     = epc_q;
  assign Flags   = flags_q;
  assign Trap    = trap_q;
  assign In_Trap = (state_q == IN_TRAP);

endmodule

// File: tb/tb_pc_branch_unit.sv
// Scoreboard bench for pc_branch_unit: the driver predicts each cycle's outcome from a
// behavioural model and queues it; the monitor compares the DUT against the queue.
module tb_pc_branch_unit;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [15:0] ALU_Result, ALU_Out;
  logic [11:0] Jump_Target;
  logic        EQ, GR, LT, Zero, Ovfl;
  logic        Flag_Write, PC_Write, PC_Write_Cond;
  logic [2:0]  Branch_Cond;
  logic [1:0]  PC_Src;
  logic        Ovfl_Trap_En, Trap_Return;
  logic [15:0] PC, EPC;
  logic [4:0]  Flags;
  logic        Branch_Taken, Trap, In_Trap;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clock = ~Clock;

  pc_branch_unit dut (
    .Clock(Clock), .Reset(Reset),
    .ALU_Result(ALU_Result), .ALU_Out(ALU_Out), .Jump_Target(Jump_Target),
    .EQ(EQ), .GR(GR), .LT(LT), .Zero(Zero), .Ovfl(Ovfl),
    .Flag_Write(Flag_Write), .PC_Write(PC_Write), .PC_Write_Cond(PC_Write_Cond),
    .Branch_Cond(Branch_Cond), .PC_Src(PC_Src),
    .Ovfl_Trap_En(Ovfl_Trap_En), .Trap_Return(Trap_Return),
    .PC(PC), .EPC(EPC), .Flags(Flags), .Branch_Taken(Branch_Taken),
    .Trap(Trap), .In_Trap(In_Trap)
  );

  typedef struct {
    int          id;
    logic        bt;
    logic [15:0] pc;
    logic [15:0] epc;
    logic [4:0]  flags;
    logic        trap;
    logic        in_trap;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state
  logic [15:0] m_pc, m_epc;
  logic [4:0]  m_flags;
  logic        m_in_trap;
  int          txn = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Condition truth from the rule table; flag names kept explicit.
  function automatic logic cond_holds(input logic [2:0] bc, input logic [4:0] f);
    logic eq, gr, lt, z;
    eq = f[0]; gr = f[1]; lt = f[2]; z = f[3];
    case (bc)
      3'd0: return eq;
      3'd1: return !eq;
      3'd2: return lt;
      3'd3: return !lt;
      3'd4: return gr;
      3'd5: return !gr;
      3'd6: return z;
      default: return 1'b1;
    endcase
  endfunction

  task automatic model_reset();
    m_pc = 16'h0000; m_epc = 16'h0000; m_flags = 5'b0; m_in_trap = 1'b0;
  endtask

  task automatic drive(input logic [15:0] res, input logic [15:0] aout, input logic [11:0] jt,
                       input logic [4:0] fl, input logic fw, input logic pw, input logic pwc,
                       input logic [2:0] bc, input logic [1:0] src, input logic ten,
                       input logic tr);
    exp_t e;
    int   target;
    @(negedge Clock);
    ALU_Result = res; ALU_Out = aout; Jump_Target = jt;
    {Ovfl, Zero, LT, GR, EQ} = fl;
    Flag_Write = fw; PC_Write = pw; PC_Write_Cond = pwc;
    Branch_Cond = bc; PC_Src = src; Ovfl_Trap_En = ten; Trap_Return = tr;

    e.id   = txn++;
    e.bt   = pwc && cond_holds(bc, m_flags);
    e.trap = 1'b0;
    case (src)
      2'd0: target = res;
      2'd1: target = aout;
      2'd2: target = (m_pc & 16'hE000) + jt * 2;
      default: target = m_epc;
    endcase
    if (m_in_trap && tr) begin
      m_pc = m_epc & 16'hFFFE;
      m_in_trap = 1'b0;
    end else if (!m_in_trap && fw && fl[4] && ten) begin
      m_epc = m_pc;
      m_pc = 16'h0004;
      m_in_trap = 1'b1;
      e.trap = 1'b1;
    end else if (pw || e.bt) begin
      m_pc = 16'(target) & 16'hFFFE;
    end
    if (fw) m_flags = fl;
    e.pc = m_pc; e.epc = m_epc; e.flags = m_flags; e.in_trap = m_in_trap;
    exp_q.push_back(e);
  endtask

  task automatic idle_inputs();
    ALU_Result = '0; ALU_Out = '0; Jump_Target = '0;
    {Ovfl, Zero, LT, GR, EQ} = 5'b0;
    Flag_Write = 0; PC_Write = 0; PC_Write_Cond = 0;
    Branch_Cond = 3'd0; PC_Src = 2'd0; Ovfl_Trap_En = 0; Trap_Return = 0;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
  task automatic reset_midcycle(input string tag);
    @(posedge Clock);
    #3;
    idle_inputs();
    Reset = 1'b1;
    #1;
    check({tag, ".PC"},      PC, 16'h0000);
    check({tag, ".EPC"},     EPC, 16'h0000);
    check({tag, ".Flags"},   {11'b0, Flags}, 16'h0000);
    check({tag, ".Trap"},    {15'b0, Trap}, 16'h0000);
    check({tag, ".In_Trap"}, {15'b0, In_Trap}, 16'h0000);
    model_reset();
    @(negedge Clock);
    Reset = 1'b0;
    $display("txn reset %s: PC=%h EPC=%h In_Trap=%b", tag, PC, EPC, In_Trap);
  endtask

  // Monitor: one queued expectation per driven cycle.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge Clock);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("Branch_Taken", {15'b0, Branch_Taken}, {15'b0, e.bt});
        @(posedge Clock);
        #1;
        check("PC",      PC, e.pc);
        check("EPC",     EPC, e.epc);
        check("Flags",   {11'b0, Flags}, {11'b0, e.flags});
        check("Trap",    {15'b0, Trap}, {15'b0, e.trap});
        check("In_Trap", {15'b0, In_Trap}, {15'b0, e.in_trap});
        $display("txn %0d: PC=%h EPC=%h Flags=%b Trap=%b In_Trap=%b BT=%b",
                 e.id, PC, EPC, Flags, Trap, In_Trap, e.bt);
      end
    end
  end

  initial begin : driver
    int k;
    idle_inputs();
    Reset = 1'b1;
    model_reset();
    repeat (2) @(negedge Clock);
    Reset = 1'b0;

    // Fetch, including bit-0 forcing
    drive(16'h0002, 0, 0, 5'b00000, 0, 1, 0, 3'd0, 2'd0, 0, 0);
    drive(16'h0004, 0, 0, 5'b00000, 0, 1, 0, 3'd0, 2'd0, 0, 0);
    drive(16'h0003, 0, 0, 5'b00000, 0, 1, 0, 3'd0, 2'd0, 0, 0);
    // Branch on latched EQ, then inverted condition
    drive(16'h0000, 0, 0, 5'b00001, 1, 0, 0, 3'd0, 2'd0, 0, 0);
    drive(16'h0000, 16'h0040, 0, 5'b00000, 0, 0, 1, 3'd0, 2'd1, 0, 0);
    drive(16'h0000, 16'h0080, 0, 5'b00000, 0, 0, 1, 3'd1, 2'd1, 0, 0);
    // Condition uses pre-edge flags even while Flag_Write rewrites them
    drive(16'h0000, 16'h0100, 0, 5'b00000, 1, 0, 1, 3'd0, 2'd1, 0, 0);
    // Jump
    drive(16'hA000, 0, 0, 5'b00000, 0, 1, 0, 3'd0, 2'd0, 0, 0);
    drive(16'h0000, 0, 12'h123, 5'b00000, 0, 1, 0, 3'd0, 2'd2, 0, 0);
    // Wrap-around value accepted unchanged
    drive(16'h0000, 0, 0, 5'b00000, 0, 1, 0, 3'd0, 2'd0, 0, 0);
    // Trap entry overrides PC_Write; second overflow masked; return
    drive(16'h0010, 0, 0, 5'b00000, 0, 1, 0, 3'd0, 2'd0, 0, 0);
    drive(16'h0100, 0, 0, 5'b10000, 1, 1, 0, 3'd0, 2'd0, 1, 0);
    drive(16'h0000, 0, 0, 5'b10000, 1, 0, 0, 3'd0, 2'd0, 1, 0);
    drive(16'h0200, 0, 0, 5'b00000, 0, 1, 0, 3'd0, 2'd0, 0, 1);
    // Return plus overflow in the same cycle; then return while idle is ignored
    drive(16'h0020, 0, 0, 5'b10000, 1, 1, 0, 3'd0, 2'd0, 1, 0);
    drive(16'h0300, 0, 0, 5'b10000, 1, 1, 0, 3'd0, 2'd0, 1, 1);
    drive(16'h0400, 0, 0, 5'b00000, 0, 0, 0, 3'd0, 2'd3, 0, 1);
    // Reset while trapped
    drive(16'h0050, 0, 0, 5'b10000, 1, 0, 0, 3'd0, 2'd0, 1, 0);
    reset_midcycle("reset_in_trap");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(16'($urandom), 16'($urandom), 12'($urandom), 5'($urandom),
            ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 1) == 1), 3'($urandom), 2'($urandom),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
      if (i == 200) reset_midcycle("reset_random");
    end

    k = 0;
    while (exp_q.size() > 0 && k < 20) begin
      @(posedge Clock);
      k++;
    end
    @(posedge Clock);
    #3;
    if (exp_q.size() > 0) check("drain", 16'(exp_q.size()), 16'h0000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
